cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
- Sits directly downstream of the reservation-station arbitrator.
- On the arbitrator's load/selection, captures the chosen station's tag and result and drives it onto the common data bus (CDB) until the consumer (ROB/register file) accepts it.
- Returns a one-hot clear pulse to free the selected station.
- Contains a 2-entry skid buffer so one grant is absorbed while the bus is held; a registered stall tells the arbitrator to stop granting.

Parameters:
- NUM_STATIONS, 8, number of reservation stations (matches `NUM_STATIONS).
- SEL_W, 4, width of the selection index; must be at least clog2(NUM_STATIONS)+1.
- TAG_W, 4, width of the destination tag.
- DATA_W, 16, width of the result word (lc3b_word).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- load  in  1  arbitrator grant valid
- selection  in  SEL_W  index of the granted station
- station_tag  in  NUM_STATIONS x TAG_W (packed)  destination tag of each station
- station_data  in  NUM_STATIONS x DATA_W (packed)  result of each station
- cdb_ready  in  1  consumer accepts the current CDB beat
- cdb_valid  out  1  CDB beat valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast result
- clear  out  NUM_STATIONS  one-hot station free pulse
- stall  out  1  buffer full; arbitrator must not grant
- overflow  out  1  sticky error flag

Behaviour:
- Reset (async, active-high): state EMPTY; cdb_valid=0, cdb_tag=0, cdb_data=0, clear=0, stall=0, overflow=0. Reset mid-broadcast discards both entries; no clear is issued for them.
- Storage: head register drives the cdb_* outputs; skid register is behind it. state is one of EMPTY, ONE, TWO.
- Accept: load=1 with selection < NUM_STATIONS is accepted unless state is TWO and cdb_ready=0.
- Capture: an accepted load samples station_tag[selection] and station_data[selection] on that clock edge.
- Drain: a beat completes in a cycle where cdb_valid=1 and cdb_ready=1.
- Transitions (acc = accepted load, drn = drain):
  - EMPTY: acc -> ONE (capture into head).
  - ONE: acc & !drn -> TWO (capture into skid); acc & drn -> ONE (head replaced by new capture); !acc & drn -> EMPTY.
  - TWO: drn -> skid moves to head; an acc in the same cycle loads skid and the state stays TWO; otherwise -> ONE. !drn: hold, and any load is dropped.
- Latency:
  - load at edge N from EMPTY -> cdb_valid=1 with the captured values after edge N.
  - clear[selection]=1 for exactly one cycle after edge N, for every accepted load, including loads captured into skid.
- cdb_valid, cdb_tag and cdb_data stay stable while cdb_valid=1 and cdb_ready=0.
- stall = (state==TWO); it is registered, with no combinational path from load.
- Dropped load: load while TWO & !cdb_ready, or selection >= NUM_STATIONS. No capture, no clear, overflow set to 1 and held until reset.
- Ordering: beats are broadcast strictly in acceptance order.
- Multiple clear bits are never asserted in the same cycle.

Optional Feature:
- Macro: CDB_PERF_CNT_EN.
- Defined: adds outputs bcast_count[15:0] and stall_count[15:0], both reset to 0.
  - bcast_count increments on each drain.
  - stall_count increments on each cycle with stall=1.
  - Both wrap from 0xFFFF to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (lc3b_types): add cdb_entry_t, a packed struct {tag, data}; reuse lc3b_word for data.
- Shared macros file: `NUM_STATIONS and the tag width constant.
- One natural sub-module: cdb_skid_buf, a 2-entry in-order buffer of cdb_entry_t with the EMPTY/ONE/TWO state.
- The top level does the station mux, clear generation, range check, overflow and the optional counters.

Test Plan:
1. Single grant: station 3 holds tag=5, data=0x1234; load=1, selection=3, cdb_ready=1 -> next cycle cdb_valid=1, tag=5, data=0x1234, clear=0x08 for one cycle; state returns to EMPTY after the drain.
2. Backpressure: cdb_ready=0; grant station 1 (tag 2, data 0xAAAA), then station 6 (tag 7, data 0xBBBB) -> stall=1 after the second edge, both clears pulsed. Then cdb_ready=1 -> beats 0xAAAA then 0xBBBB in order; stall drops.
3. Overflow: TWO with cdb_ready=0; load with selection=4 -> no clear, beats unchanged, overflow=1 and still 1 after 10 further cycles.
4. Out-of-range: load with selection=9 (NUM_STATIONS=8) -> no capture, no clear, overflow=1.
5. Simultaneous: ONE with cdb_ready=1 plus a load of station 0 (tag 1, data 0x0F0F) -> old beat drains, next cycle cdb_data=0x0F0F, state ONE.
6. Async reset: assert rst mid-TWO between edges -> all outputs 0 immediately. With CDB_PERF_CNT_EN, counters are 0 and 3 drains give bcast_count=3.

Source files
------------

// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and constants for the CDB broadcaster: station count, field widths,
// the broadcast entry layout and the buffer occupancy states.
package cdb_broadcaster_pkg;

    localparam int NUM_STATIONS = 8;
    localparam int SEL_W        = 4;
    localparam int TAG_W        = 4;
    localparam int DATA_W       = 16;
    localparam int IDX_W        = $clog2(NUM_STATIONS);

    typedef logic [DATA_W-1:0] lc3b_word;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        lc3b_word         data;
    } cdb_entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    function automatic logic [NUM_STATIONS-1:0] station_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_STATIONS-1:0] result;
        result      = '0;
        result[idx] = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Arbitrator/consumer-facing bus of the CDB broadcaster. The master modport is the
// environment (arbitrator + ROB), the slave modport is the broadcaster itself.
interface cdb_broadcaster_if;
    import cdb_broadcaster_pkg::*;

    logic                                load;
    logic [SEL_W-1:0]                    selection;
    logic [NUM_STATIONS-1:0][TAG_W-1:0]  station_tag;
    logic [NUM_STATIONS-1:0][DATA_W-1:0] station_data;
    logic                                cdb_ready;
    logic                                cdb_valid;
    logic [TAG_W-1:0]                    cdb_tag;
    logic [DATA_W-1:0]                   cdb_data;
    logic [NUM_STATIONS-1:0]             clear;
    logic                                stall;
    logic                                overflow;

    modport master (
        output load, selection, station_tag, station_data, cdb_ready,
        input  cdb_valid, cdb_tag, cdb_data, clear, stall, overflow
    );

    modport slave (
        input  load, selection, station_tag, station_data, cdb_ready,
        output cdb_valid, cdb_tag, cdb_data, clear, stall, overflow
    );

endinterface

// File: rtl/cdb_broadcaster_skid_buf.sv
// Two-entry in-order buffer: the head entry drives the bus, the skid entry absorbs
// one extra grant while the head is being held by backpressure.
module cdb_skid_buf
    import cdb_broadcaster_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  cdb_entry_t push_entry_i,
    input  logic       ready_i,
    output logic       room_o,
    output logic       valid_o,
    output logic       full_o,
    output cdb_entry_t head_o
);

    buf_state_e state_q, state_d;
    cdb_entry_t head_q, head_d;
    cdb_entry_t skid_q, skid_d;
    logic       drain_s;

    assign valid_o = (state_q != BUF_EMPTY);
    assign full_o  = (state_q == BUF_TWO);
    assign head_o  = head_q;
    assign drain_s = valid_o & ready_i;
    assign room_o  = ~(full_o & ~ready_i);

    // Occupancy and entry movement for the next cycle
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push_i) begin
                    head_d  = push_entry_i;
                    state_d = BUF_ONE;
                end else begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_ONE: begin
                if (push_i && drain_s) begin
                    head_d = push_entry_i;
                end else if (push_i) begin
                    skid_d  = push_entry_i;
                    state_d = BUF_TWO;
                end else if (drain_s) begin
                    state_d = BUF_EMPTY;
                end else begin
                    state_d = BUF_ONE;
                end
            end
            BUF_TWO: begin
                if (drain_s) begin
                    head_d = skid_q;
                    if (push_i) begin
                        skid_d = push_entry_i;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end else begin
                    state_d = BUF_TWO;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

    // Buffer state and storage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB broadcaster top: station mux, range check, clear pulse, sticky overflow.
// Optional performance counters are enabled with the macro CDB_PERF_CNT_EN.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cdb_broadcaster_if.slave   bus
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [15:0]        bcast_count_o,
    output logic [15:0]        stall_count_o
`endif
);

    logic                    in_range_s;
    logic [IDX_W-1:0]        sel_idx_s;
    logic                    room_s;
    logic                    accept_s;
    logic                    drop_s;
    logic                    valid_s;
    logic                    full_s;
    cdb_entry_t              capture_s;
    cdb_entry_t              head_s;
    logic [NUM_STATIONS-1:0] clear_q, clear_d;
    logic                    overflow_q, overflow_d;

    assign in_range_s     = (bus.selection < SEL_W'(NUM_STATIONS));
    assign sel_idx_s      = bus.selection[IDX_W-1:0];
    assign accept_s       = bus.load & in_range_s & room_s;
    assign drop_s         = bus.load & ~accept_s;
    assign capture_s.tag  = bus.station_tag[sel_idx_s];
    assign capture_s.data = bus.station_data[sel_idx_s];

    cdb_skid_buf u_skid_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (accept_s),
        .push_entry_i (capture_s),
        .ready_i      (bus.cdb_ready),
        .room_o       (room_s),
        .valid_o      (valid_s),
        .full_o       (full_s),
        .head_o       (head_s)
    );

    // Clear pulse and sticky overflow next-state
    always_comb begin
        clear_d    = '0;
        overflow_d = overflow_q | drop_s;
        if (accept_s) begin
            clear_d = station_onehot(sel_idx_s);
        end else begin
            clear_d = '0;
        end
    end

    // Clear and overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            clear_q    <= clear_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.cdb_valid = valid_s;
    assign bus.cdb_tag   = head_s.tag;
    assign bus.cdb_data  = head_s.data;
    assign bus.clear     = clear_q;
    assign bus.stall     = full_s;
    assign bus.overflow  = overflow_q;

`ifdef CDB_PERF_CNT_EN
    logic [15:0] bcast_count_q, bcast_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    // Counter next-state; both wrap naturally at 16 bits
    always_comb begin
        bcast_count_d = bcast_count_q;
        stall_count_d = stall_count_q;
        if (valid_s && bus.cdb_ready) begin
            bcast_count_d = bcast_count_q + 16'd1;
        end else begin
            bcast_count_d = bcast_count_q;
        end
        if (full_s) begin
            stall_count_d = stall_count_q + 16'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcast_count_q <= 16'd0;
            stall_count_q <= 16'd0;
        end else begin
            bcast_count_q <= bcast_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bcast_count_o = bcast_count_q;
    assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed scenarios with literal expectations,
// then randomized traffic against a queue-based model of the broadcast order.
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdb_broadcaster_if bus ();

    cdb_broadcaster dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cdb_entry_t mq[$];
    logic [7:0] m_clear;
    bit         m_ovf;
    bit         cmp_en;
    int         errors;
    int         checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_station(input int s, input logic [3:0] tag, input logic [15:0] data);
        bus.station_tag[s]  = tag;
        bus.station_data[s] = data;
    endtask

    task automatic model_reset();
        mq.delete();
        m_clear = 8'd0;
        m_ovf   = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict the outcome, advance the model after the edge
    task automatic step(input bit ld, input int sel, input bit rdy);
        bit         drn;
        bit         acc;
        cdb_entry_t ent;
        logic [3:0] sel4;
        sel4          = 4'(sel);
        bus.load      = ld;
        bus.selection = sel4;
        bus.cdb_ready = rdy;
        drn = (mq.size() > 0) && rdy;
        acc = ld && (sel < 8) && !((mq.size() == 2) && !rdy);
        ent = '0;
        if (acc) begin
            ent.tag  = bus.station_tag[sel4[2:0]];
            ent.data = bus.station_data[sel4[2:0]];
        end
        @(posedge clk);
        #1;
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(ent);
        m_clear = acc ? (8'd1 << sel) : 8'd0;
        if (ld && !acc) m_ovf = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Every cycle, compare the DUT bus against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_valid", 32'(bus.cdb_valid), 32'(mq.size() > 0));
            chk("cyc_stall", 32'(bus.stall), 32'(mq.size() == 2));
            chk("cyc_overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("cyc_clear", 32'(bus.clear), 32'(m_clear));
            if (mq.size() > 0) begin
                chk("cyc_tag", 32'(bus.cdb_tag), 32'(mq[0].tag));
                chk("cyc_data", 32'(bus.cdb_data), 32'(mq[0].data));
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        cmp_en = 1'b0;
        bus.load = 1'b0;
        bus.selection = 4'd0;
        bus.cdb_ready = 1'b0;
        bus.station_tag = '0;
        bus.station_data = '0;
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.cdb_valid), 32'd0);
        chk("rst_tag", 32'(bus.cdb_tag), 32'd0);
        chk("rst_data", 32'(bus.cdb_data), 32'd0);
        chk("rst_clear", 32'(bus.clear), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Single grant
        set_station(3, 4'd5, 16'h1234);
        step(1'b1, 3, 1'b1);
        chk("t1_valid", 32'(bus.cdb_valid), 32'd1);
        chk("t1_tag", 32'(bus.cdb_tag), 32'd5);
        chk("t1_data", 32'(bus.cdb_data), 32'h1234);
        chk("t1_clear", 32'(bus.clear), 32'h08);
        step(1'b0, 0, 1'b1);
        chk("t1_empty", 32'(bus.cdb_valid), 32'd0);
        chk("t1_clear_gone", 32'(bus.clear), 32'd0);

        // Backpressure
        set_station(1, 4'd2, 16'hAAAA);
        set_station(6, 4'd7, 16'hBBBB);
        step(1'b1, 1, 1'b0);
        chk("t2_clear1", 32'(bus.clear), 32'h02);
        step(1'b1, 6, 1'b0);
        chk("t2_stall", 32'(bus.stall), 32'd1);
        chk("t2_clear6", 32'(bus.clear), 32'h40);
        chk("t2_head", 32'(bus.cdb_data), 32'hAAAA);
        step(1'b0, 0, 1'b1);
        chk("t2_second", 32'(bus.cdb_data), 32'hBBBB);
        chk("t2_tag7", 32'(bus.cdb_tag), 32'd7);
        chk("t2_unstall", 32'(bus.stall), 32'd0);
        step(1'b0, 0, 1'b1);
        chk("t2_drained", 32'(bus.cdb_valid), 32'd0);

        // Overflow while full
        step(1'b1, 1, 1'b0);
        step(1'b1, 6, 1'b0);
        step(1'b1, 4, 1'b0);
        chk("t3_noclear", 32'(bus.clear), 32'd0);
        chk("t3_head", 32'(bus.cdb_data), 32'hAAAA);
        chk("t3_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b0);
        chk("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
        chk("t3_head_hold", 32'(bus.cdb_data), 32'hAAAA);
        pulse_reset();

        // Out-of-range selection
        step(1'b1, 9, 1'b1);
        chk("t4_valid", 32'(bus.cdb_valid), 32'd0);
        chk("t4_clear", 32'(bus.clear), 32'd0);
        chk("t4_ovf", 32'(bus.overflow), 32'd1);
        pulse_reset();

        // Simultaneous drain and capture
        set_station(0, 4'd1, 16'h0F0F);
        step(1'b1, 3, 1'b1);
        step(1'b1, 0, 1'b1);
        chk("t5_data", 32'(bus.cdb_data), 32'h0F0F);
        chk("t5_tag", 32'(bus.cdb_tag), 32'd1);
        chk("t5_one", 32'(bus.stall), 32'd0);
        step(1'b0, 0, 1'b1);

        // Asynchronous reset while full
        step(1'b1, 1, 1'b0);
        step(1'b1, 6, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("t6_valid", 32'(bus.cdb_valid), 32'd0);
        chk("t6_tag", 32'(bus.cdb_tag), 32'd0);
        chk("t6_data", 32'(bus.cdb_data), 32'd0);
        chk("t6_clear", 32'(bus.clear), 32'd0);
        chk("t6_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int sel;
            for (int s = 0; s < 8; s++) set_station(s, 4'($urandom), 16'($urandom));
            sel = ($urandom % 20 == 0) ? 8 + int'($urandom % 8) : int'($urandom % 8);
            step(($urandom % 3) != 0, sel, ($urandom % 2) == 1);
            if ((c % 500) == 499) pulse_reset();
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
